fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetch FSM with sequential,
// branch, JAL and JALR redirection and a sticky misaligned-target fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic [1:0]  next_PC_select,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] JAL_target,
  input  logic [31:0] JALR_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_PC,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        redirect;

  assign seq_pc = pc + 32'd4;

  // Candidate next PC; only acted on in HOLD with stall low
  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    unique case (next_PC_select)
      2'b00: ;
      2'b01: if (branch) begin
        target   = branch_target;
        redirect = 1'b1;
      end
      2'b10: begin
        target   = JAL_target;
        redirect = 1'b1;
      end
      2'b11: begin
        target   = {JALR_target[31:1], 1'b0};
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      IDLE: if (start) state_next = REQ;
      REQ:  if (imem_ready) state_next = WAIT;
      WAIT: if (imem_rvalid) state_next = HOLD;
      HOLD: if (!stall) begin
        if (redirect && (target[1:0] != 2'b00)) begin
          state_next = FAULT;
        end else begin
          pc_next    = target;
          state_next = REQ;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_PC    <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == WAIT && imem_rvalid) begin
        inst    <= imem_rdata;
        inst_PC <= pc;
      end
      if (state_next == FAULT) misaligned <= 1'b1;
    end
  end

  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, compared every cycle against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, start, stall, branch;
  logic [1:0]  next_PC_select;
  logic [31:0] branch_target, JAL_target, JALR_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, misaligned;
  logic [31:0] inst, inst_PC;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .next_PC_select(next_PC_select), .branch(branch),
    .branch_target(branch_target), .JAL_target(JAL_target),
    .JALR_target(JALR_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
    .inst_PC(inst_PC), .misaligned(misaligned)
  );

  // Reference model: what the fetcher is currently doing, as flags
  bit          m_requesting, m_waiting, m_holding, m_faulted;
  logic [31:0] m_pc, m_inst, m_inst_pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    bit          jump;
    if (reset) begin
      m_requesting = 0; m_waiting = 0; m_holding = 0; m_faulted = 0;
      m_pc = RST_PC; m_inst = 0; m_inst_pc = 0;
    end else if (m_faulted) begin
      // only reset leaves a fault
    end else if (m_holding) begin
      if (!stall) begin
        nxt  = m_pc + 32'd4;
        jump = 0;
        if (next_PC_select == 2'd1 && branch) begin nxt = branch_target; jump = 1; end
        if (next_PC_select == 2'd2) begin nxt = JAL_target; jump = 1; end
        if (next_PC_select == 2'd3) begin nxt = JALR_target & ~32'd1; jump = 1; end
        m_holding = 0;
        if (jump && (nxt % 4 != 0)) m_faulted = 1;
        else begin m_pc = nxt; m_requesting = 1; end
      end
    end else if (m_waiting) begin
      if (imem_rvalid) begin
        m_waiting = 0; m_holding = 1; m_inst = imem_rdata; m_inst_pc = m_pc;
      end
    end else if (m_requesting) begin
      if (imem_ready) begin m_requesting = 0; m_waiting = 1; end
    end else if (start) begin
      m_requesting = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("imem_req",   {31'b0, imem_req},   {31'b0, m_requesting});
    check_eq("imem_addr",  imem_addr,           m_pc);
    check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, m_holding});
    check_eq("inst",       inst,                m_inst);
    check_eq("inst_PC",    inst_PC,             m_inst_pc);
    check_eq("misaligned", {31'b0, misaligned}, {31'b0, m_faulted});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic fetch(input logic [31:0] data);
    imem_ready = 1; cycle(); imem_ready = 0;
    imem_rvalid = 1; imem_rdata = data; cycle(); imem_rvalid = 0;
  endtask

  task automatic consume(input logic [1:0] sel, input logic br,
                         input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt);
    next_PC_select = sel; branch = br;
    branch_target = bt; JAL_target = jt; JALR_target = jrt;
    stall = 0; cycle(); stall = 1;
    next_PC_select = 2'd0; branch = 0;
    branch_target = 32'hDEAD_BEEF; JAL_target = 32'hDEAD_BEEF; JALR_target = 32'hDEAD_BEEF;
  endtask

  initial begin
    reset = 1; start = 0; stall = 1; branch = 0; next_PC_select = 2'd0;
    branch_target = 0; JAL_target = 0; JALR_target = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    m_pc = RST_PC; m_inst = 0; m_inst_pc = 0;
    @(negedge clock);
    cycle(); cycle();
    check_eq("reset_addr", imem_addr, RST_PC);
    reset = 0;

    // first fetch and sequential consume
    start = 1; cycle(); start = 0;
    check_eq("first_req", {31'b0, imem_req}, 32'd1);
    fetch(32'h0050_0093);
    check_eq("first_inst", inst, 32'h0050_0093);
    check_eq("first_inst_pc", inst_PC, 32'h0);
    consume(2'b00, 0, 0, 0, 0);
    check_eq("seq_addr", imem_addr, 32'h4);

    // conditional branch taken then not taken
    fetch(32'h1111_0001);
    consume(2'b01, 1, 32'h40, 0, 0);
    check_eq("br_taken", imem_addr, 32'h40);
    fetch(32'h1111_0002);
    consume(2'b01, 0, 32'h80, 0, 0);
    check_eq("br_not_taken", imem_addr, 32'h44);

    // memory back-pressure with spurious rvalid, then held instruction
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    repeat (3) begin
      cycle();
      check_eq("req_hold_addr", imem_addr, 32'h44);
      check_eq("spurious_valid", {31'b0, inst_valid}, 32'd0);
    end
    imem_rvalid = 0;
    fetch(32'h2222_0003);
    repeat (5) begin
      cycle();
      check_eq("stall_inst", inst, 32'h2222_0003);
    end

    // PC wrap via JAL to the top of the address space
    consume(2'b10, 0, 0, 32'hFFFF_FFFC, 0);
    check_eq("jal_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h3333_0004);
    consume(2'b00, 0, 0, 0, 0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // JALR: bit 0 cleared, then a target misaligned in bit 1
    fetch(32'h4444_0005);
    consume(2'b11, 0, 0, 0, 32'h0000_0081);
    check_eq("jalr_addr", imem_addr, 32'h80);
    check_eq("jalr_nofault", {31'b0, misaligned}, 32'd0);
    fetch(32'h4444_0006);
    consume(2'b11, 0, 0, 0, 32'h0000_0103);
    check_eq("jalr_fault", {31'b0, misaligned}, 32'd1);
    check_eq("fault_req", {31'b0, imem_req}, 32'd0);
    check_eq("fault_pc", imem_addr, 32'h80);
    start = 1; stall = 0; imem_ready = 1;
    repeat (3) cycle();
    start = 0; stall = 1; imem_ready = 0;

    // reset while waiting on memory; late rvalid ignored
    reset = 1; cycle(); reset = 0;
    start = 1; cycle(); start = 0;
    imem_ready = 1; cycle(); imem_ready = 0;
    reset = 1; cycle(); reset = 0;
    imem_rvalid = 1; imem_rdata = 32'h5555_5555; cycle(); imem_rvalid = 0;
    check_eq("late_rvalid", {31'b0, inst_valid}, 32'd0);
    check_eq("late_pc", imem_addr, RST_PC);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      start          = ($urandom_range(0, 3) == 0);
      stall          = $urandom_range(0, 1);
      imem_ready     = $urandom_range(0, 1);
      imem_rvalid    = ($urandom_range(0, 4) < 2);
      imem_rdata     = $urandom;
      next_PC_select = 2'($urandom_range(0, 3));
      branch         = $urandom_range(0, 1);
      branch_target  = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      JAL_target     = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      JALR_target    = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
